// File: rtl/mem_copy_engine_pkg.sv
// Shared widths, state encoding and mode constants for the memory copy/fill engine.
package mem_copy_engine_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int LEN_W  = ADDR_W + 1;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(32);

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_CAP,
        WR,
        DONE
    } state_t;

    // Lengths beyond the memory size would revisit bytes, so they saturate at one full pass.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > MAX_LEN) ? MAX_LEN : l;
    endfunction

endpackage

// File: rtl/mem_copy_engine.sv
// Bus initiator that copies or fills bytes in the data memory, one byte per
// read/capture/write sequence (copy) or one byte per cycle (fill).
module mem_copy_engine
    import mem_copy_engine_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [DATA_W-1:0] read_data,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    output logic              mem_write_sig,
    output logic              busy,
    output logic              done
);

    state_t state;
    state_t next_state;

    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [LEN_W-1:0]  remaining;
    logic              mode_reg;
    logic [DATA_W-1:0] fill_reg;
    logic [DATA_W-1:0] data_reg;
    logic [ADDR_W-1:0] last_address;
    logic [DATA_W-1:0] last_write_data;

    logic [LEN_W-1:0]  start_len;

    assign start_len = clamp_len(len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The bus holds its last driven address/data in non-writing states, so the
    // previously driven values are kept as registers and used as the default.
    always_comb begin
        next_state    = state;
        address       = last_address;
        write_data    = last_write_data;
        mem_write_sig = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (start_len == '0) begin
                        next_state = DONE;
                    end else if (mode == MODE_COPY) begin
                        next_state = RD_ADDR;
                    end else begin
                        next_state = WR;
                    end
                end
            end
            RD_ADDR: begin
                address    = src_ptr;
                next_state = RD_CAP;
            end
            RD_CAP: begin
                address    = src_ptr;
                next_state = WR;
            end
            WR: begin
                address       = dst_ptr;
                write_data    = (mode_reg == MODE_FILL) ? fill_reg : data_reg;
                mem_write_sig = 1'b1;
                if (remaining == LEN_W'(1)) begin
                    next_state = DONE;
                end else if (mode_reg == MODE_COPY) begin
                    next_state = RD_ADDR;
                end else begin
                    next_state = WR;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_ptr         <= '0;
            dst_ptr         <= '0;
            remaining       <= '0;
            mode_reg        <= MODE_COPY;
            fill_reg        <= '0;
            data_reg        <= '0;
            last_address    <= '0;
            last_write_data <= '0;
        end else begin
            last_address    <= address;
            last_write_data <= write_data;
            if (state == IDLE && start) begin
                src_ptr   <= src;
                dst_ptr   <= dst;
                remaining <= start_len;
                mode_reg  <= mode;
                fill_reg  <= fill_value;
            end
            if (state == RD_CAP) begin
                data_reg <= read_data;
            end
            // Pointers wrap naturally at the address width.
            if (state == WR) begin
                src_ptr   <= src_ptr + ADDR_W'(1);
                dst_ptr   <= dst_ptr + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: a behavioural byte memory responds on
// the bus while expected strobes and done pulses are queued and checked.
module tb_mem_copy_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [4:0] src = '0;
    logic [4:0] dst = '0;
    logic [5:0] len = '0;
    logic [7:0] fill_value = '0;
    logic [7:0] read_data;
    logic [4:0] address;
    logic [7:0] write_data;
    logic       mem_write_sig;
    logic       busy;
    logic       done;

    logic [7:0] mem     [32];
    logic [7:0] ref_mem [32];
    logic [7:0] snap    [32];

    logic       poke_en = 1'b0;
    logic [4:0] poke_addr = '0;
    logic [7:0] poke_data = '0;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int strobe_count = 0;
    int done_count = 0;

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
        int         c;
    } wr_t;

    wr_t wq[$];
    int  dq[$];

    mem_copy_engine dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mode          (mode),
        .src           (src),
        .dst           (dst),
        .len           (len),
        .fill_value    (fill_value),
        .read_data     (read_data),
        .address       (address),
        .write_data    (write_data),
        .mem_write_sig (mem_write_sig),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign read_data = mem[address];

    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (mem_write_sig) begin
            mem[address] <= write_data;
        end
    end

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe and done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_write_sig) begin
                strobe_count++;
                if (wq.size() == 0) begin
                    check_output("strobe_expected", 0, 1);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check_output("wr_addr", address, e.a);
                    check_output("wr_data", write_data, e.d);
                    check_output("wr_cycle", cyc, e.c);
                end
            end
            if (done) begin
                done_count++;
                if (dq.size() == 0) begin
                    check_output("done_expected", 0, 1);
                end else begin
                    int ec;
                    ec = dq.pop_front();
                    check_output("done_cycle", cyc, ec);
                end
            end
        end
    end

    // Sequential C-loop reference; s0 is the cyc value seen during cycle 1.
    task automatic push_expect(input logic m, input logic [4:0] s, input logic [4:0] d,
                               input logic [5:0] l, input logic [7:0] f, input int s0);
        int  n;
        wr_t e;
        n = (l > 6'd32) ? 32 : int'(l);
        for (int k = 0; k < n; k++) begin
            e.a = 5'(int'(d) + k);
            e.d = m ? f : ref_mem[5'(int'(s) + k)];
            e.c = m ? (s0 + k) : (s0 + 3 * k + 2);
            ref_mem[e.a] = e.d;
            wq.push_back(e);
        end
        dq.push_back(m ? (s0 + n) : (s0 + 3 * n));
    endtask

    task automatic wait_done(input int target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            if (done_count >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_output("done_timeout", 0, 1);
    endtask

    task automatic poke(input logic [4:0] a, input logic [7:0] v);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = v;
        ref_mem[a] = v;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic apply_stimulus(input logic m, input logic [4:0] s, input logic [4:0] d,
                                  input logic [5:0] l, input logic [7:0] f, input int nexp);
        int s0;
        int d0;
        strobe_count = 0;
        d0 = done_count;
        @(negedge clk);
        mode = m;
        src = s;
        dst = d;
        len = l;
        fill_value = f;
        start = 1'b1;
        @(posedge clk);
        #1;
        s0 = cyc;
        start = 1'b0;
        push_expect(m, s, d, l, f, s0);
        wait_done(d0 + 1);
        check_output("strobe_count", strobe_count, nexp);
        check_output("wq_drained", wq.size(), 0);
        check_output("dq_drained", dq.size(), 0);
    endtask

    initial begin
        int s0;
        int d0;

        for (int i = 0; i < 32; i++) poke(5'(i), 8'(8'h80 + i));
        poke(5'd0, 8'hAA);
        poke(5'd1, 8'hBB);
        poke(5'd2, 8'hCC);
        poke(5'd3, 8'hDD);

        #1;
        check_output("rst_address", address, 0);
        check_output("rst_write_data", write_data, 0);
        check_output("rst_strobe", mem_write_sig, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        // Plain copy
        apply_stimulus(1'b0, 5'd0, 5'd16, 6'd4, 8'h00, 4);
        check_output("copy_m16", mem[16], 8'hAA);
        check_output("copy_m17", mem[17], 8'hBB);
        check_output("copy_m18", mem[18], 8'hCC);
        check_output("copy_m19", mem[19], 8'hDD);

        // Fill with untouched neighbours
        apply_stimulus(1'b1, 5'd0, 5'd8, 6'd5, 8'h5A, 5);
        check_output("fill_m8", mem[8], 8'h5A);
        check_output("fill_m12", mem[12], 8'h5A);
        check_output("fill_m7", mem[7], 8'h87);
        check_output("fill_m13", mem[13], 8'h8D);

        // Source and destination wrap
        apply_stimulus(1'b0, 5'd30, 5'd2, 6'd4, 8'h00, 4);
        check_output("wrap_m2", mem[2], 8'h9E);
        check_output("wrap_m3", mem[3], 8'h9F);
        check_output("wrap_m4", mem[4], 8'hAA);
        check_output("wrap_m5", mem[5], 8'hBB);
        apply_stimulus(1'b1, 5'd0, 5'd31, 6'd2, 8'h33, 2);
        check_output("wrapfill_m31", mem[31], 8'h33);
        check_output("wrapfill_m0", mem[0], 8'h33);

        // Forward overlap replicates the leading byte
        poke(5'd0, 8'h11);
        poke(5'd1, 8'h22);
        apply_stimulus(1'b0, 5'd0, 5'd1, 6'd3, 8'h00, 3);
        check_output("ovl_m1", mem[1], 8'h11);
        check_output("ovl_m2", mem[2], 8'h11);
        check_output("ovl_m3", mem[3], 8'h11);

        // Zero length: done in cycle 1, busy for one cycle only
        strobe_count = 0;
        d0 = done_count;
        @(negedge clk);
        mode = 1'b0; src = 5'd0; dst = 5'd9; len = 6'd0; start = 1'b1;
        @(posedge clk);
        #1;
        s0 = cyc;
        start = 1'b0;
        push_expect(1'b0, 5'd0, 5'd9, 6'd0, 8'h00, s0);
        check_output("len0_busy_c1", busy, 1);
        check_output("len0_done_c1", done, 1);
        @(posedge clk);
        #1;
        check_output("len0_busy_c2", busy, 0);
        check_output("len0_strobes", strobe_count, 0);
        check_output("len0_dq", dq.size(), 0);

        // Reset during the second write of a copy
        snap = ref_mem;
        @(negedge clk);
        mode = 1'b0; src = 5'd16; dst = 5'd24; len = 6'd4; start = 1'b1;
        @(posedge clk);
        #1;
        s0 = cyc;
        start = 1'b0;
        push_expect(1'b0, 5'd16, 5'd24, 6'd4, 8'h00, s0);
        repeat (5) @(posedge clk);
        #1;
        check_output("midrst_strobe_before", mem_write_sig, 1);
        check_output("midrst_addr_before", address, 25);
        #1 rst = 1'b1;
        #1;
        check_output("midrst_strobe_async", mem_write_sig, 0);
        check_output("midrst_address", address, 0);
        check_output("midrst_write_data", write_data, 0);
        check_output("midrst_busy", busy, 0);
        check_output("midrst_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        check_output("midrst_m24", mem[24], 8'hAA);
        check_output("midrst_m25", mem[25], 8'h99);
        wq.delete();
        dq.delete();
        ref_mem = snap;
        ref_mem[24] = snap[16];
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(1'b1, 5'd0, 5'd20, 6'd1, 8'h44, 1);
        check_output("post_rst_m20", mem[20], 8'h44);

        // Start held high: accepted once, then again only from IDLE
        strobe_count = 0;
        d0 = done_count;
        @(negedge clk);
        mode = 1'b1; src = 5'd0; dst = 5'd10; len = 6'd2; fill_value = 8'h66; start = 1'b1;
        @(posedge clk);
        #1;
        s0 = cyc;
        push_expect(1'b1, 5'd0, 5'd10, 6'd2, 8'h66, s0);
        push_expect(1'b1, 5'd0, 5'd10, 6'd2, 8'h66, s0 + 4);
        repeat (3) @(posedge clk);
        #1;
        check_output("held_idle_busy", busy, 0);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(d0 + 2);
        repeat (2) @(posedge clk);
        check_output("held_strobes", strobe_count, 4);
        check_output("held_done_pulses", done_count - d0, 2);
        check_output("held_m10", mem[10], 8'h66);
        check_output("held_m11", mem[11], 8'h66);

        // Oversized length saturates at a full pass
        apply_stimulus(1'b1, 5'd0, 5'd0, 6'd40, 8'h77, 32);
        check_output("clamp_m0", mem[0], 8'h77);
        check_output("clamp_m31", mem[31], 8'h77);

        for (int i = 0; i < 32; i++) check_output("final_mem", mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
